// File: rtl/adc_pack_pkg.sv
// Shared types and sizing helpers for the N-channel ADC aligner/packer.
// Provides the FSM state enum, beat/word sizing and the sample slot offset.
package adc_pack_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   // Aligned beats that fit in one output word.
   function automatic int beats(int out_w, int n_ch, int sw);
      return out_w / (n_ch * sw);
   endfunction

   // Width of a counter that can hold 0..beats.
   function automatic int cnt_w(int out_w, int n_ch, int sw);
      return $clog2(beats(out_w, n_ch, sw) + 1);
   endfunction

   // LSB of channel ch in beat slot beat; beat 0 and channel 0 sit at the MSB end.
   function automatic int slot_lo(int out_w, int n_ch, int sw, int beat, int ch);
      return out_w - beat * n_ch * sw - (ch + 1) * sw;
   endfunction

endpackage

// File: rtl/adc_pack_out_reg.sv
// Output holding register with valid/ready handshake; contents hold on stall.
// Ports: load_i/data_i/last_i load a word (caller ensures the slot is free), ready_i from downstream.
module adc_pack_out_reg #(
   parameter int W = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         last_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      // A load in the transfer cycle keeps the stream at one word per cycle.
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/adc_multi_packer.sv
// N-channel ADC sample aligner and packer with framing, flush, backpressure and skew monitor.
// Ports: in_* from per-channel FWFT FIFOs, out_* valid/ready word stream, skew_err, frames_done.
module adc_multi_packer
   import adc_pack_pkg::*;
#(
   parameter int N_CH     = 2,
   parameter int SAMPLE_W = 16,
   parameter int OUT_W    = 256,
   parameter int SKEW_MAX = 64,
   parameter int FLEN_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [N_CH-1:0]          ch_en,
   input  logic [FLEN_W-1:0]        frame_len,
   input  logic [N_CH*SAMPLE_W-1:0] in_data,
   input  logic [N_CH-1:0]          in_valid,
   output logic [N_CH-1:0]          in_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     skew_err,
   output logic [FLEN_W-1:0]        frames_done
);

   localparam int BEATS = beats(OUT_W, N_CH, SAMPLE_W);
   localparam int CW    = cnt_w(OUT_W, N_CH, SAMPLE_W);
   localparam int SKW   = $clog2(SKEW_MAX + 1);
   localparam int IW    = $clog2(OUT_W);

   state_t              state_q, state_d;
   logic [N_CH-1:0]     mask_q, mask_d;
   logic [FLEN_W-1:0]   flen_q, flen_d;
   logic [OUT_W-1:0]    acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                full_q, full_d;
   logic                acc_last_q, acc_last_d;
   logic [FLEN_W-1:0]   fbeat_q, fbeat_d;
   logic [FLEN_W-1:0]   frames_q, frames_d;
   logic [SKW-1:0]      skew_cnt_q, skew_cnt_d;
   logic                skew_err_q, skew_err_d;

   logic                ld;
   logic [OUT_W-1:0]    ld_data;
   logic                ld_last;
   logic                out_free;
   logic                fire;
   logic                all_v;
   logic                any_v;
   logic                frame_end;
   logic [OUT_W-1:0]    word;
   logic [CW-1:0]       base_cnt;
   logic [CW-1:0]       wcnt;
   logic [IW-1:0]       lo;

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      flen_d     = flen_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      full_d     = full_q;
      acc_last_d = acc_last_q;
      fbeat_d    = fbeat_q;
      frames_d   = frames_q;
      skew_cnt_d = '0;
      skew_err_d = skew_err_q;
      ld         = 1'b0;
      ld_data    = acc_q;
      ld_last    = acc_last_q;
      in_ready   = '0;
      fire       = 1'b0;
      frame_end  = 1'b0;
      word       = acc_q;
      base_cnt   = cnt_q;
      wcnt       = cnt_q;
      lo         = '0;
      all_v      = &(in_valid | ~mask_q);
      any_v      = |(in_valid & mask_q);
      out_free   = !out_valid || out_ready;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               mask_d = ch_en;
               flen_d = frame_len;
               if (|ch_en) begin
                  state_d    = RUN;
                  skew_err_d = 1'b0;
               end
            end
         end

         RUN: begin
            fire     = all_v && (!full_q || out_free);
            in_ready = fire ? '1 : ~mask_q;

            // A completed word parked in the accumulator moves out first.
            if (full_q && out_free) begin
               ld         = 1'b1;
               ld_data    = acc_q;
               ld_last    = acc_last_q;
               full_d     = 1'b0;
               acc_last_d = 1'b0;
               cnt_d      = '0;
               acc_d      = '0;
            end

            if (fire) begin
               word     = full_q ? '0 : acc_q;
               base_cnt = full_q ? '0 : cnt_q;
               for (int i = 0; i < N_CH; i++) begin
                  if (mask_q[i]) begin
                     lo = IW'(slot_lo(OUT_W, N_CH, SAMPLE_W,
                                      int'(base_cnt), i));
                     word[lo +: SAMPLE_W] =
                        in_data[i*SAMPLE_W +: SAMPLE_W];
                  end
               end
               wcnt = base_cnt + 1'b1;

               if (flen_q != '0) begin
                  frame_end = (fbeat_q + 1'b1 == flen_q);
                  fbeat_d   = frame_end ? '0 : fbeat_q + 1'b1;
                  if (frame_end) begin
                     frames_d = frames_q + 1'b1;
                  end
               end

               if (wcnt == CW'(BEATS) || frame_end) begin
                  if (out_free && !ld) begin
                     ld      = 1'b1;
                     ld_data = word;
                     ld_last = frame_end;
                     acc_d   = '0;
                     cnt_d   = '0;
                  end else begin
                     acc_d      = word;
                     cnt_d      = wcnt;
                     full_d     = 1'b1;
                     acc_last_d = frame_end;
                  end
               end else begin
                  acc_d = word;
                  cnt_d = wcnt;
               end
            end

            if (any_v && !all_v) begin
               skew_cnt_d = (skew_cnt_q == SKW'(SKEW_MAX)) ?
                            skew_cnt_q : skew_cnt_q + 1'b1;
               if (skew_cnt_d == SKW'(SKEW_MAX)) begin
                  skew_err_d = 1'b1;
               end
            end

            if (!en) begin
               state_d = FLUSH;
               fbeat_d = '0;
            end
         end

         FLUSH: begin
            fbeat_d = '0;
            if (cnt_q != '0) begin
               if (out_free) begin
                  ld         = 1'b1;
                  ld_data    = acc_q;
                  // A word that was already complete keeps its own marker.
                  ld_last    = full_q ? acc_last_q : 1'b1;
                  acc_d      = '0;
                  cnt_d      = '0;
                  full_d     = 1'b0;
                  acc_last_d = 1'b0;
               end
            end else if (!out_valid) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         flen_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         acc_last_q <= 1'b0;
         fbeat_q    <= '0;
         frames_q   <= '0;
         skew_cnt_q <= '0;
         skew_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         flen_q     <= flen_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         acc_last_q <= acc_last_d;
         fbeat_q    <= fbeat_d;
         frames_q   <= frames_d;
         skew_cnt_q <= skew_cnt_d;
         skew_err_q <= skew_err_d;
      end
   end

   adc_pack_out_reg #(
      .W (OUT_W)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (ld),
      .data_i  (ld_data),
      .last_i  (ld_last),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .last_o  (out_last)
   );

   assign skew_err    = skew_err_q;
   assign frames_done = frames_q;

endmodule

// File: doc/adc_multi_packer.md
Name: adc_multi_packer

Overview:
- Parametrised N-channel ADC sample aligner and packer, single clock domain.
- Sits after the per-channel ADC CDC buffer FIFOs, which are first-word-fall-through and already in the system clock domain. Sits before the wide adc-to-RAM FIFO.
- Pops one sample from every enabled channel only in a cycle where all of them have data. Packs the aligned beats into OUT_W-bit words.
- Adds channel masking, frame-length framing with a last marker, flush on disable, output backpressure, and a skew-error monitor.

Parameters:
- N_CH, 2, number of ADC channels.
- SAMPLE_W, 16, bits per channel sample.
- OUT_W, 256, output word width. Must be a multiple of N_CH*SAMPLE_W.
- SKEW_MAX, 64, cycles an enabled channel may sit valid while another enabled channel is empty before the error flag sets.
- FLEN_W, 16, width of frame_len and frames_done.

Ports:
- clk  in  1  system/read clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable. Deasserting it flushes any partial word.
- ch_en  in  N_CH  channel enable mask. Sampled only in IDLE.
- frame_len  in  FLEN_W  beats per frame; 0 means unframed. Sampled only in IDLE.
- in_data  in  N_CH*SAMPLE_W  channel i occupies bits [(i+1)*SAMPLE_W-1 : i*SAMPLE_W].
- in_valid  in  N_CH  per-channel FIFO not-empty/valid.
- in_ready  out  N_CH  per-channel FIFO rd_en.
- out_data  out  OUT_W  packed word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  word closes a frame or a flush.
- skew_err  out  1  sticky channel-misalignment flag.
- frames_done  out  FLEN_W  completed-frame counter; wraps.

Behaviour:
- Definitions: B = N_CH*SAMPLE_W; BEATS = OUT_W/B; a beat is one aligned sample set.
- Reset values: every output is 0 and the FSM is in IDLE.
- IDLE state:
  - in_ready = 0.
  - When en=1, latch ch_en and frame_len, then go to RUN.
  - If the latched mask is all zero, stay in IDLE.
- RUN state, fire condition:
  - fire = AND over enabled channels of in_valid, AND acc_ok.
  - acc_ok = accumulator not full, OR the output register is empty or draining this cycle.
- RUN state, in_ready:
  - Enabled channels: in_ready[i] = fire.
  - Disabled channels: in_ready[i] = 1; their data is discarded.
- Packing order:
  - Within a beat, channel 0 sits in the most-significant SAMPLE_W slot.
  - Within a word, the first beat sits in the most-significant B bits.
  - This matches the downstream width-conversion FIFO ordering.
  - Disabled-channel slots are zero.
- Word completion:
  - A word completes on the BEATS-th beat, or on the frame's last beat, whichever comes first.
  - A short word is zero-padded in its lower unused beats.
  - Completion moves the accumulator to the output register; out_valid rises the next cycle.
  - Latency: completing beat accepted at cycle t → out_valid=1 at t+1.
- Output handshake:
  - The word transfers on out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - A new word may load into the output register in the same cycle the current one transfers, giving sustained one beat per cycle.
- Framing (frame_len ≠ 0):
  - A beat counter counts 1..frame_len.
  - On beat frame_len, out_last=1 for that word, frames_done increments (wrapping), and the counter resets.
- Unframed (frame_len = 0): out_last=0, except on a flush word.
- Disable: en=0 in RUN goes to FLUSH.
- FLUSH state:
  - in_ready = 0.
  - If the accumulator is non-empty, emit it zero-padded with out_last=1 once the output register is free.
  - Then wait for the output register to drain, and go to IDLE.
  - The frame beat counter clears.
  - An empty accumulator goes straight to the drain wait.
- Skew monitor, RUN only:
  - A counter increments while at least one enabled channel is valid and at least one is not.
  - The counter clears otherwise.
  - Reaching SKEW_MAX sets skew_err.
  - skew_err clears only on rst_n, or on the IDLE→RUN transition.
- Asynchronous reset mid-word drops the accumulator and output register contents; no partial output.
- Changes to ch_en or frame_len during RUN or FLUSH are ignored.

Decomposition:
- Package adc_pack_pkg holds:
  - state enum (IDLE, RUN, FLUSH);
  - localparam functions BEATS and the beat-index width clog2(BEATS+1);
  - the sample slot-offset function.
- One sub-module, adc_pack_out_reg: output holding register with valid/ready and hold-on-stall.

Test Plan:
- Continuous data, defaults (N_CH=2, SAMPLE_W=16, OUT_W=256):
  - Stimulus: ch0 samples 0x1000.., ch1 samples 0x2000.., out_ready=1, frame_len=0.
  - Response: first word = {1000,2000,1001,2001,…,1007,2007}; one word every 8 cycles; out_last=0.
- Channel skew:
  - Stimulus: ch1 valid 3 cycles after ch0.
  - Response: no in_ready until both are valid; in_ready on both together; word content identical to the first scenario; skew_err=0.
- Frame of 5 beats:
  - Stimulus: frame_len=5, run 10 beats.
  - Response: two words, each holding 5 beats in the upper 160 bits, lower 96 bits zero, out_last=1; frames_done=2.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles mid-stream.
  - Response: out_data stable; in_ready drops after the next word completes; no data lost or duplicated once released.
- Mask and flush:
  - Stimulus: ch_en=2'b01, 3 beats, then en=0.
  - Response: ch1 drained with in_ready=1; one word with ch1 slots zero and 3 beats populated, out_last=1; FSM returns to IDLE.
- Skew error:
  - Stimulus: only ch0 valid for 64 cycles.
  - Response: skew_err=1 at cycle 64, staying set until re-arm; asynchronous reset asserted mid-word clears all outputs immediately.
